// File: rtl/lcd_pattern_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pattern_pkg : shared types, palette and panel defaults for the pattern source
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lcd_pattern_pkg;

  typedef logic [15:0] rgb565_t;

  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_e;

  localparam int DEF_SCREEN_X = 480;
  localparam int DEF_SCREEN_Y = 272;

  function automatic rgb565_t palette(input logic [2:0] idx);
    rgb565_t c;
    c = 16'h0000;
    case (idx)
      3'd0: c = 16'hF800;
      3'd1: c = 16'h07E0;
      3'd2: c = 16'h001F;
      3'd3: c = 16'hFFE0;
      3'd4: c = 16'h07FF;
      3'd5: c = 16'hF81F;
      3'd6: c = 16'hFFFF;
      3'd7: c = 16'hFD20;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/square_pattern_gen_bounce_axis.sv
// ---------------------------------------------------------------------------
// bounce_axis : one axis of the bouncing square, position plus INC/DEC direction
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bounce_axis
  import lcd_pattern_pkg::*;
#(
  parameter int W    = 10,
  parameter int MAX  = 330,
  parameter int STEP = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_en,
  output logic [W-1:0] pos,
  output logic         bounce
);

  localparam logic [W:0] C_MAX  = (W+1)'(MAX);
  localparam logic [W:0] C_STEP = (W+1)'(STEP);

  logic [W-1:0] pos_q, pos_d;
  dir_e         dir_q, dir_d;
  logic [W:0]   sum_up;

  // One bit of headroom so pos+STEP near the top of the range cannot wrap.
  assign sum_up = {1'b0, pos_q} + C_STEP;

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    bounce = 1'b0;
    if (step_en) begin
      if (dir_q == DIR_INC) begin
        if (sum_up >= C_MAX) begin
          pos_d  = C_MAX[W-1:0];
          dir_d  = DIR_DEC;
          bounce = 1'b1;
        end else begin
          pos_d = sum_up[W-1:0];
        end
      end else begin
        if ({1'b0, pos_q} <= C_STEP) begin
          pos_d  = '0;
          dir_d  = DIR_INC;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - C_STEP[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;

endmodule

`default_nettype wire

// File: rtl/square_pattern_gen.sv
// ---------------------------------------------------------------------------
// square_pattern_gen : bouncing coloured square over a flat background, RGB565
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module square_pattern_gen
  import lcd_pattern_pkg::*;
#(
  parameter int      SCREEN_X = DEF_SCREEN_X,
  parameter int      SCREEN_Y = DEF_SCREEN_Y,
  parameter int      SQUARE_X = 150,
  parameter int      SQUARE_Y = 150,
  parameter int      STEP     = 2,
  parameter rgb565_t BG_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_start,
  input  logic        pix_de,
  input  logic [9:0]  pix_x,
  input  logic [8:0]  pix_y,
  output logic [15:0] rgb_out,
  output logic        rgb_de,
  output logic [9:0]  sq_x,
  output logic [8:0]  sq_y,
  output logic [7:0]  bounce_cnt
);

  localparam logic [10:0] C_XSPAN = 11'(SQUARE_X - 1);
  localparam logic [9:0]  C_YSPAN = 10'(SQUARE_Y - 1);

  logic       step_en;
  logic       bounce_x, bounce_y;
  logic [2:0] color_idx_q, color_idx_d;
  logic [7:0] bounce_cnt_q, bounce_cnt_d;
  rgb565_t    rgb_q, rgb_d;
  logic       de_q, de_d;
  logic       hit;

  assign step_en = frame_start & enable;

  bounce_axis #(.W(10), .MAX(SCREEN_X - SQUARE_X), .STEP(STEP)) u_axis_x (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .pos     (sq_x),
    .bounce  (bounce_x)
  );

  bounce_axis #(.W(9), .MAX(SCREEN_Y - SQUARE_Y), .STEP(STEP)) u_axis_y (
    .clk     (clk),
    .rst     (rst),
    .step_en (step_en),
    .pos     (sq_y),
    .bounce  (bounce_y)
  );

  // Widened compares keep the far edge of the square from wrapping.
  assign hit = ({1'b0, pix_x} >= {1'b0, sq_x}) && ({1'b0, pix_x} <= ({1'b0, sq_x} + C_XSPAN)) &&
               ({1'b0, pix_y} >= {1'b0, sq_y}) && ({1'b0, pix_y} <= ({1'b0, sq_y} + C_YSPAN));

  always_comb begin
    color_idx_d  = color_idx_q;
    bounce_cnt_d = bounce_cnt_q;
    if (bounce_x || bounce_y) begin
      color_idx_d  = color_idx_q + 3'd1;
      bounce_cnt_d = bounce_cnt_q + 8'd1;
    end
    de_d  = pix_de;
    rgb_d = 16'h0000;
    if (pix_de) rgb_d = hit ? palette(color_idx_q) : BG_COLOR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_idx_q  <= 3'd0;
      bounce_cnt_q <= 8'd0;
      rgb_q        <= 16'h0000;
      de_q         <= 1'b0;
    end else begin
      color_idx_q  <= color_idx_d;
      bounce_cnt_q <= bounce_cnt_d;
      rgb_q        <= rgb_d;
      de_q         <= de_d;
    end
  end

  assign rgb_out    = rgb_q;
  assign rgb_de     = de_q;
  assign bounce_cnt = bounce_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_square_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_square_pattern_gen : scoreboard bench for the bouncing-square pattern source
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_square_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default geometry, STEP=2
  logic        en_a = 1'b1, fs_a = 1'b0, de_a = 1'b0;
  logic [9:0]  px_a = '0;
  logic [8:0]  py_a = '0;
  logic [15:0] rgb_a;
  logic        rde_a;
  logic [9:0]  sqx_a;
  logic [8:0]  sqy_a;
  logic [7:0]  bc_a;

  // Instance B: STEP=1, YMAX=110 so both axes bounce on frame 330
  logic        en_b = 1'b1, fs_b = 1'b0, de_b = 1'b0;
  logic [9:0]  px_b = '0;
  logic [8:0]  py_b = '0;
  logic [15:0] rgb_b;
  logic        rde_b;
  logic [9:0]  sqx_b;
  logic [8:0]  sqy_b;
  logic [7:0]  bc_b;

  square_pattern_gen dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .frame_start(fs_a), .pix_de(de_a),
    .pix_x(px_a), .pix_y(py_a), .rgb_out(rgb_a), .rgb_de(rde_a),
    .sq_x(sqx_a), .sq_y(sqy_a), .bounce_cnt(bc_a)
  );

  square_pattern_gen #(.SCREEN_Y(260), .STEP(1)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .frame_start(fs_b), .pix_de(de_b),
    .pix_x(px_b), .pix_y(py_b), .rgb_out(rgb_b), .rgb_de(rde_b),
    .sq_x(sqx_b), .sq_y(sqy_b), .bounce_cnt(bc_b)
  );

  typedef struct {
    int          cyc;
    bit          which;
    logic [15:0] rgb;
    logic        de;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each pixel issued in cycle k must show up on the outputs in cycle k+1
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc != cyc - 1) begin
        check("pix_latency", cyc - e.cyc, 1);
      end else if (e.which) begin
        check("rgb_b", rgb_b, e.rgb);
        check("rde_b", rde_b, e.de);
      end else begin
        check("rgb_a", rgb_a, e.rgb);
        check("rde_a", rde_a, e.de);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames_a(input int n, input logic en);
    en_a = en;
    for (int i = 0; i < n; i++) begin
      fs_a = 1'b1;
      tick();
      fs_a = 1'b0;
    end
    en_a = 1'b1;
  endtask

  task automatic frames_b(input int n);
    for (int i = 0; i < n; i++) begin
      fs_b = 1'b1;
      tick();
      fs_b = 1'b0;
    end
  endtask

  task automatic pix_a(input int x, input int y, input logic de, input logic [15:0] exp_rgb);
    exp_t e;
    px_a = 10'(x); py_a = 9'(y); de_a = de;
    e.cyc = cyc; e.which = 1'b0; e.rgb = de ? exp_rgb : 16'h0000; e.de = de;
    q.push_back(e);
    tick();
    de_a = 1'b0;
  endtask

  task automatic pix_b(input int x, input int y, input logic [15:0] exp_rgb);
    exp_t e;
    px_b = 10'(x); py_b = 9'(y); de_b = 1'b1;
    e.cyc = cyc; e.which = 1'b1; e.rgb = exp_rgb; e.de = 1'b1;
    q.push_back(e);
    tick();
    de_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    tick(); tick();
    check("rst_sqx", sqx_a, 0);
    check("rst_sqy", sqy_a, 0);
    check("rst_bcnt", bc_a, 0);
    check("rst_rgb", rgb_a, 0);
    check("rst_rde", rde_a, 0);
    rst = 1'b0;
    tick();

    // Rendering at (0,0), colour 0
    pix_a(0, 0, 1'b1, 16'hF800);
    pix_a(149, 149, 1'b1, 16'hF800);
    pix_a(150, 0, 1'b1, 16'h0000);
    pix_a(0, 150, 1'b1, 16'h0000);
    pix_a(149, 150, 1'b1, 16'h0000);
    pix_a(10, 10, 1'b0, 16'h0000);
    tick();

    frames_a(1, 1'b1);
    check("f1_sqx", sqx_a, 2);
    check("f1_sqy", sqy_a, 2);
    check("f1_bcnt", bc_a, 0);
    pix_a(1, 1, 1'b1, 16'h0000);
    pix_a(2, 2, 1'b1, 16'hF800);

    frames_a(60, 1'b1);
    check("f61_sqx", sqx_a, 122);
    check("f61_sqy", sqy_a, 122);
    check("f61_bcnt", bc_a, 1);
    pix_a(122, 122, 1'b1, 16'h07E0);

    frames_a(1, 1'b1);
    check("f62_sqy_dec", sqy_a, 120);

    frames_a(103, 1'b1);
    check("f165_sqx", sqx_a, 330);
    check("f165_sqy", sqy_a, 86);
    check("f165_bcnt", bc_a, 3);
    pix_a(330, 86, 1'b1, 16'hFFE0);
    pix_a(329, 86, 1'b1, 16'h0000);

    frames_a(1, 1'b1);
    check("f166_sqx_dec", sqx_a, 328);
    check("f166_sqy", sqy_a, 88);

    frames_a(5, 1'b0);
    check("hold_sqx", sqx_a, 328);
    check("hold_sqy", sqy_a, 88);
    check("hold_bcnt", bc_a, 3);

    frames_a(1, 1'b1);
    check("resume_sqx", sqx_a, 326);
    check("resume_sqy", sqy_a, 90);
    check("resume_bcnt", bc_a, 3);

    // Asynchronous reset in the middle of motion with a lit pixel on the output
    do_reset();
    frames_a(20, 1'b1);
    check("pre_rst_sqx", sqx_a, 40);
    begin
      exp_t e;
      px_a = 10'd40; py_a = 9'd40; de_a = 1'b1;
      e.cyc = cyc; e.which = 1'b0; e.rgb = 16'hF800; e.de = 1'b1;
      q.push_back(e);
      tick();
      @(negedge clk);
      #1;
      check("pre_rst_rgb", rgb_a, 16'hF800);
      rst = 1'b1;
      #1;
      check("async_sqx", sqx_a, 0);
      check("async_rgb", rgb_a, 0);
      check("async_rde", rde_a, 0);
      de_a = 1'b0;
    end
    tick();
    rst = 1'b0;
    tick();
    frames_a(1, 1'b1);
    check("post_rst_sqx", sqx_a, 2);

    // Corner bounce on instance B
    do_reset();
    frames_b(329);
    check("b329_sqx", sqx_b, 329);
    check("b329_sqy", sqy_b, 109);
    check("b329_bcnt", bc_b, 2);
    pix_b(329, 109, 16'h001F);
    frames_b(1);
    check("b330_sqx", sqx_b, 330);
    check("b330_sqy", sqy_b, 110);
    check("b330_bcnt", bc_b, 3);
    pix_b(330, 110, 16'hFFE0);
    pix_b(329, 110, 16'h0000);

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() != 0) check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
